// File: rtl/ysyx_23060136_ifu_bpu.sv
// Fetch-stage branch predictor: gshare counter table, global history register and
// a return-address stack, producing a same-cycle redirect for the fetched instruction.
module ysyx_23060136_ifu_bpu #(
  parameter int XLEN      = 64,
  parameter int IDX_W     = 9,
  parameter int CNT_W     = 2,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_if,
  input  logic                           if_valid,
  input  logic [31:0]                    if_inst,
  input  logic [XLEN-1:0]                if_pc,
  input  logic                           res_valid,
  input  logic [XLEN-1:0]                res_pc,
  input  logic                           res_taken,
  input  logic                           res_mispredict,
  input  logic [((GHR_W>0)?GHR_W:1)-1:0] res_ghr,
  output logic                           pred_take,
  output logic [XLEN-1:0]                pred_target,
  output logic                           flush_if,
  output logic [((GHR_W>0)?GHR_W:1)-1:0] pred_ghr
);

  localparam int GW      = (GHR_W > 0) ? GHR_W : 1;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int RP_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

  // ---------------- decode ----------------
  logic [6:0] opcode;
  logic [4:0] rd, rs1;
  logic       is_br, is_jal, is_jalr, rd_link, rs1_link, is_call, is_ret;
  logic [XLEN-1:0] imm_b, imm_j;

  assign opcode   = if_inst[6:0];
  assign rd       = if_inst[11:7];
  assign rs1      = if_inst[19:15];
  assign is_br    = (opcode == 7'b1100011);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  // rd=link wins: jalr with both fields linked is a call, never a ret
  assign is_call  = (is_jal || is_jalr) && rd_link;
  assign is_ret   = is_jalr && rs1_link && !rd_link;

  assign imm_b = {{(XLEN-12){if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  // ---------------- history / indexing ----------------
  logic [GW-1:0]    ghr;
  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] upd_cnt;
  logic             br_taken;

  assign br_taken = cnt_q[fetch_idx][CNT_W-1];
  assign upd_cnt  = cnt_q[upd_idx];

  logic unused_res_pc;
  assign unused_res_pc = ^{res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  generate
    if (GHR_W == 0) begin : g_bimodal
      assign ghr       = '0;
      assign fetch_idx = if_pc[IDX_W+1:2];
      assign upd_idx   = res_pc[IDX_W+1:2];
      logic unused_res_ghr;
      assign unused_res_ghr = ^{res_ghr, res_mispredict};
    end else begin : g_gshare
      logic [GW-1:0] shift_fetch, shift_res;
      assign fetch_idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr);
      assign upd_idx   = res_pc[IDX_W+1:2] ^ IDX_W'(res_ghr);
      if (GHR_W == 1) begin : g_one
        assign shift_fetch = br_taken;
        assign shift_res   = res_taken;
      end else begin : g_many
        assign shift_fetch = {ghr[GW-2:0], br_taken};
        assign shift_res   = {res_ghr[GW-2:0], res_taken};
      end

      // A mispredict repair outranks the speculative shift from the fetched branch
      always_ff @(posedge clk) begin
        if (rst)
          ghr <= '0;
        else if (!stall_if) begin
          if (res_valid && res_mispredict)
            ghr <= shift_res;
          else if (if_valid && is_br)
            ghr <= shift_fetch;
        end
      end
    end
  endgenerate

  // ---------------- counter table ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (res_valid && !stall_if) begin
      if (res_taken && upd_cnt != CNT_MAX)
        cnt_q[upd_idx] <= upd_cnt + CNT_W'(1);
      else if (!res_taken && upd_cnt != '0)
        cnt_q[upd_idx] <= upd_cnt - CNT_W'(1);
    end
  end

  // ---------------- return-address stack ----------------
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [RP_W-1:0] ras_ptr, ptr_dec;
  logic [RC_W-1:0] ras_cnt;
  logic            ras_hit, push, pop;

  assign ptr_dec = ras_ptr - RP_W'(1);
  assign ras_hit = (ras_cnt != '0);
  assign push    = if_valid && is_call && !stall_if;
  assign pop     = if_valid && is_ret && ras_hit && !stall_if;

  // Circular buffer: a push when full silently overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + RP_W'(1);
      if (ras_cnt != RC_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + RC_W'(1);
    end else if (pop) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ras_ptr] <= if_pc + XLEN'(4);
  end

  // ---------------- prediction ----------------
  always_comb begin
    pred_take   = 1'b0;
    pred_target = '0;
    if (if_valid) begin
      if (is_jal) begin
        pred_take   = 1'b1;
        pred_target = if_pc + imm_j;
      end else if (is_br && br_taken) begin
        pred_take   = 1'b1;
        pred_target = if_pc + imm_b;
      end else if (is_ret && ras_hit) begin
        pred_take   = 1'b1;
        pred_target = ras_q[ptr_dec];
      end
    end
  end

  assign flush_if = pred_take;
  assign pred_ghr = if_valid ? ghr : '0;

endmodule

// File: tb/tb_ysyx_23060136_ifu_bpu.sv
// Directed scenarios plus randomized traffic, checked against an arithmetic/queue
// model of the predictor (counter array, history integer, return-address queue).
module tb_ysyx_23060136_ifu_bpu;

  logic        clk = 1'b0;
  logic        rst, stall_if, if_valid, res_valid, res_taken, res_mispredict;
  logic [31:0] if_inst;
  logic [63:0] if_pc, res_pc, pred_target;
  logic [7:0]  res_ghr, pred_ghr;
  logic        pred_take, flush_if;

  always #5 clk = ~clk;

  ysyx_23060136_ifu_bpu #(.XLEN(64), .IDX_W(9), .CNT_W(2), .GHR_W(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_ghr(res_ghr), .pred_take(pred_take),
    .pred_target(pred_target), .flush_if(flush_if), .pred_ghr(pred_ghr)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cnt_m [512];
  int          ghr_m;
  logic [63:0] ras_m [$];

  localparam logic [31:0] BEQ16 = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JAL1  = 32'h0080_00EF;  // jal x1,+8
  localparam logic [31:0] RET0  = 32'h0000_8067;  // jalr x0,0(x1)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) cnt_m[i] = 1;
    ghr_m = 0;
    ras_m.delete();
  endtask

  function automatic void decode(input logic [31:0] inst, output logic br, output logic jal,
                                 output logic call, output logic ret);
    int op  = int'(inst & 32'h7F);
    int rdv = int'((inst >> 7) & 32'h1F);
    int rsv = int'((inst >> 15) & 32'h1F);
    bit rdl = (rdv == 1) || (rdv == 5);
    bit rsl = (rsv == 1) || (rsv == 5);
    bit jr  = (op == 'h67);
    br   = (op == 'h63);
    jal  = (op == 'h6F);
    call = (jal || jr) && rdl;
    ret  = jr && rsl && !rdl;
  endfunction

  function automatic int idx_of(input logic [63:0] pc, input int g);
    return int'((pc >> 2) & 64'h1FF) ^ g;
  endfunction

  function automatic void model_pred(input logic [31:0] inst, input logic [63:0] pc,
                                     output logic take, output logic [63:0] tgt);
    logic br, jal, call, ret;
    int v;
    logic [63:0] off;
    decode(inst, br, jal, call, ret);
    take = 1'b0;
    tgt  = '0;
    if (jal) begin
      v = (int'(inst[31]) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11)
        | (int'(inst[30:21]) << 1);
      if (v >= (1 << 20)) v -= (1 << 21);
      off  = longint'(v);
      take = 1'b1;
      tgt  = pc + off;
    end else if (br) begin
      if (cnt_m[idx_of(pc, ghr_m)] >= 2) begin
        v = (int'(inst[31]) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5)
          | (int'(inst[11:8]) << 1);
        if (v >= 4096) v -= 8192;
        off  = longint'(v);
        take = 1'b1;
        tgt  = pc + off;
      end
    end else if (ret && ras_m.size() > 0) begin
      take = 1'b1;
      tgt  = ras_m[$];
    end
  endfunction

  task automatic model_update(input logic et);
    logic br, jal, call, ret;
    int ri;
    if (rst) begin
      model_reset();
      return;
    end
    if (stall_if) return;
    decode(if_inst, br, jal, call, ret);
    if (res_valid) begin
      ri = idx_of(res_pc, int'(res_ghr));
      if (res_taken) cnt_m[ri] = (cnt_m[ri] == 3) ? 3 : cnt_m[ri] + 1;
      else           cnt_m[ri] = (cnt_m[ri] == 0) ? 0 : cnt_m[ri] - 1;
    end
    if (res_valid && res_mispredict) ghr_m = ((int'(res_ghr) << 1) | int'(res_taken)) & 255;
    else if (if_valid && br)         ghr_m = ((ghr_m << 1) | int'(et)) & 255;
    if (if_valid && call) begin
      ras_m.push_back(if_pc + 64'd4);
      if (ras_m.size() > 4) void'(ras_m.pop_front());
    end else if (if_valid && ret && ras_m.size() > 0) begin
      void'(ras_m.pop_back());
    end
  endtask

  // Inputs are already driven; compare outputs to the model, clock once, advance the model.
  task automatic cycle(input string tag);
    logic        et;
    logic [63:0] etg;
    #2;
    if (if_valid) model_pred(if_inst, if_pc, et, etg);
    else begin et = 1'b0; etg = '0; end
    chk({tag, " take"}, {63'd0, pred_take}, {63'd0, et});
    chk({tag, " flush"}, {63'd0, flush_if}, {63'd0, et});
    if (et || !if_valid) chk({tag, " target"}, pred_target, etg);
    chk({tag, " ghr"}, {56'd0, pred_ghr}, if_valid ? 64'(ghr_m) : 64'd0);
    @(posedge clk);
    model_update(et);
    #1;
  endtask

  task automatic idle();
    stall_if = 0; if_valid = 0; if_inst = '0; if_pc = '0;
    res_valid = 0; res_pc = '0; res_taken = 0; res_mispredict = 0; res_ghr = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle("reset"); rst = 0;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [63:0] pc);
    if_valid = 1; if_inst = inst; if_pc = pc;
  endtask

  task automatic resolve(input logic [63:0] pc, input logic tk, input logic mis, input logic [7:0] g);
    res_valid = 1; res_pc = pc; res_taken = tk; res_mispredict = mis; res_ghr = g;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 9);
    if (k <= 3) i[6:0] = 7'b1100011;
    else if (k <= 5) begin i[6:0] = 7'b1101111; i[11:7] = pick_reg(); end
    else if (k <= 8) begin i[6:0] = 7'b1100111; i[11:7] = pick_reg(); i[19:15] = pick_reg(); end
    else i[6:0] = 7'b0010011;
    return i;
  endfunction

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return {32'($urandom), 32'($urandom)} & ~64'd3;
    return 64'h8000_0000 + 64'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 0;

    // reset state and a branch fetched right after reset
    cycle("idle");
    fetch(BEQ16, 64'h8000_0000);
    #1;
    chk("post_rst take", {63'd0, pred_take}, 64'd0);
    chk("post_rst flush", {63'd0, flush_if}, 64'd0);
    chk("post_rst ghr", {56'd0, pred_ghr}, 64'd0);
    cycle("r31_fetch0");
    idle();
    resolve(64'h8000_0000, 1, 0, 8'h00);
    cycle("r31_res1");
    cycle("r31_res2");
    idle();
    fetch(BEQ16, 64'h8000_0000);
    #1;
    chk("trained take", {63'd0, pred_take}, 64'd1);
    chk("trained target", pred_target, 64'h8000_0010);
    cycle("r31_fetch1");

    // saturation at 11, then one step down still predicts taken
    do_reset();
    resolve(64'h8000_0040, 1, 0, 8'h00);
    repeat (4) cycle("r32_up");
    resolve(64'h8000_0040, 0, 0, 8'h00);
    cycle("r32_down");
    idle();
    fetch(BEQ16, 64'h8000_0040);
    #1;
    chk("sat10 take", {63'd0, pred_take}, 64'd1);
    cycle("r32_fetch");
    idle();
    resolve(64'h8000_0040, 0, 1, 8'h00);
    cycle("r32_down2");
    idle();
    fetch(BEQ16, 64'h8000_0040);
    #1;
    chk("sat01 take", {63'd0, pred_take}, 64'd0);
    cycle("r32_fetch2");

    // mispredict restore beats the fetch shift
    do_reset();
    resolve(64'h8000_0100, 1, 1, 8'h02);
    cycle("r33_set5");
    fetch(BEQ16, 64'h8000_0000);
    resolve(64'h8000_0100, 1, 1, 8'h0A);
    #1;
    chk("ghr before", {56'd0, pred_ghr}, 64'h05);
    cycle("r33_both");
    idle();
    fetch(32'h0000_0013, 64'h8000_0000);
    #1;
    chk("ghr restored", {56'd0, pred_ghr}, 64'h15);
    cycle("r33_after");

    // call / return pair, then return on an empty stack
    do_reset();
    fetch(JAL1, 64'h100);
    #1;
    chk("jal target", pred_target, 64'h108);
    cycle("r34_call");
    fetch(RET0, 64'h108);
    #1;
    chk("ret take", {63'd0, pred_take}, 64'd1);
    chk("ret target", pred_target, 64'h104);
    cycle("r34_ret");
    fetch(RET0, 64'h200);
    #1;
    chk("ret empty", {63'd0, pred_take}, 64'd0);
    cycle("r34_ret2");

    // overflow overwrites the oldest entry
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(JAL1, 64'(i * 16));
      cycle("r35_call");
    end
    for (int i = 0; i < 4; i++) begin
      fetch(RET0, 64'h300);
      #1;
      chk("ovf ret target", pred_target, 64'(68 - i * 16));
      cycle("r35_ret");
    end
    fetch(RET0, 64'h300);
    #1;
    chk("ovf ret empty", {63'd0, pred_take}, 64'd0);
    cycle("r35_ret5");

    // stall freezes counters, history and stack
    fetch(JAL1, 64'h500);
    cycle("r36_call");
    idle();
    resolve(64'h8000_0000, 1, 1, 8'h19);
    cycle("r36_ghr33");
    stall_if = 1;
    fetch(JAL1, 64'h600);
    resolve(64'h8000_0080, 1, 1, 8'h33);
    cycle("r36_stall");
    idle();
    fetch(RET0, 64'h700);
    #1;
    chk("stall ras", pred_target, 64'h504);
    chk("stall ghr", {56'd0, pred_ghr}, 64'h33);
    cycle("r36_ret");
    fetch(BEQ16, 64'h8000_0080);
    #1;
    chk("stall cnt", {63'd0, pred_take}, 64'd0);
    cycle("r36_br");

    // wraparound target
    fetch(JAL1, 64'hFFFF_FFFF_FFFF_FFFC);
    #1;
    chk("wrap target", pred_target, 64'h4);
    cycle("wrap");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      stall_if = ($urandom_range(0, 6) == 0);
      if_valid = ($urandom_range(0, 4) != 0);
      if_inst  = rand_inst();
      if_pc    = rand_pc();
      res_valid      = ($urandom_range(0, 2) != 0);
      res_pc         = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 4;
      res_taken      = 1'($urandom);
      res_mispredict = ($urandom_range(0, 3) == 0);
      res_ghr        = ($urandom_range(0, 1) == 0) ? 8'(ghr_m) : 8'($urandom);
      cycle("rand");
    end
    rst = 0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
